// File: rtl/fp16_mul_arb_pkg.sv
// ---------------------------------------------------------------------------
// fp16_mul_arb_pkg
// Shared definitions for the FP16 multiplier arbiter: FSM state encoding,
// FP16 word width and the quiet-NaN pattern returned on a watchdog timeout.
// ---------------------------------------------------------------------------
package fp16_mul_arb_pkg;

  localparam int FP16_W = 16;
  localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    CLEAR,
    RESP
  } state_t;

endpackage

// File: rtl/fm_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fm_rr_arbiter
// Combinational round-robin pick. The search starts at ptr and walks upward
// modulo NUM_REQ; the first requester found with req_valid high wins.
//
// Ports
//   req_valid  in   NUM_REQ  per-requester request
//   ptr        in   ID_W     highest-priority index for this pick
//   grant      out  NUM_REQ  one-hot winner (all zero when no request)
//   grant_id   out  ID_W     encoded winner index (0 when no request)
// ---------------------------------------------------------------------------
module fm_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    // NOTE: every variable gets a default before the loop so that no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp16_mul_arbiter.sv
// ---------------------------------------------------------------------------
// fp16_mul_arbiter
// Shares one fp16_multiplier between NUM_REQ requesters. A round-robin grant
// latches the winner's operands, pulses mul_start, waits for mul_valid,
// pulses mul_clear and returns the product tagged with the winner's index on
// a valid/ready response channel. One operation is in flight at a time.
// The multiplier itself is held in reset (reset_b = ~reset) by the level
// that instantiates both blocks.
//
// Optional feature: define FM_ARB_TIMEOUT_EN to add a WAIT watchdog that
// returns qNaN with rsp_err=1 after TIMEOUT_CYCLES cycles without mul_valid.
//
// Ports
//   clk, reset             single clock, synchronous active-high reset
//   req_valid/req_ready    per-requester request / one-hot accept (IDLE only)
//   req_a, req_b           packed FP16 operands, requester i at [16i+15:16i]
//   rsp_valid/rsp_ready    response handshake
//   rsp_id, rsp_data       owner index and FP16 product
//   rsp_err                watchdog timeout flag (0 without FM_ARB_TIMEOUT_EN)
//   mul_a, mul_b           registered operands to the multiplier
//   mul_start, mul_clear   one-cycle pulses to the multiplier
//   mul_valid, mul_result  multiplier completion and product
//   busy                   high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module fp16_mul_arbiter
  import fp16_mul_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [FP16_W*NUM_REQ-1:0]    req_a,
  input  logic [FP16_W*NUM_REQ-1:0]    req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [FP16_W-1:0]            rsp_data,
  output logic                         rsp_err,
  output logic [FP16_W-1:0]            mul_a,
  output logic [FP16_W-1:0]            mul_b,
  output logic                         mul_start,
  output logic                         mul_clear,
  input  logic                         mul_valid,
  input  logic [FP16_W-1:0]            mul_result,
  output logic                         busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic [FP16_W-1:0]   a_arr [NUM_REQ];
  logic [FP16_W-1:0]   b_arr [NUM_REQ];

  fm_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  // Operand lanes unpacked so the winner can be selected by index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = req_a[i*FP16_W +: FP16_W];
      b_arr[i] = req_b[i*FP16_W +: FP16_W];
    end
  end

  // Accept is only offered in IDLE; masking with reset keeps the port quiet
  // while the block is being reset even if requesters are still asserting.
  assign req_ready = (state == IDLE && !reset) ? grant : '0;

`ifdef FM_ARB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  // Single FSM block; mul_start, mul_clear, rsp_valid and busy are registered
  // together with the state so each is high for exactly the matching state.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignment so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      mul_start <= 1'b0;
      mul_clear <= 1'b0;
      busy      <= 1'b0;
`ifdef FM_ARB_TIMEOUT_EN
      rsp_err   <= 1'b0;
      tmo_cnt   <= '0;
`endif
    end else begin
      mul_start <= 1'b0;
      mul_clear <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            mul_a     <= a_arr[grant_id];
            mul_b     <= b_arr[grant_id];
            rsp_id    <= grant_id;
            mul_start <= 1'b1;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          // A stale mul_valid here is deliberately ignored.
`ifdef FM_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (mul_valid) begin
            rsp_data  <= mul_result;
            mul_clear <= 1'b1;
            state     <= CLEAR;
          end
`ifdef FM_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_data  <= FP16_QNAN;
            rsp_err   <= 1'b1;
            mul_clear <= 1'b1;
            state     <= CLEAR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        CLEAR: begin
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            ptr       <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
`ifdef FM_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp16_mul_arbiter
// Randomized bench for fp16_mul_arbiter. A behavioural multiplier answers
// mul_start after a programmable latency with an FP16 product computed by
// integer arithmetic; a round-robin model predicts each grant; every
// response is compared against those predictions.
// ---------------------------------------------------------------------------
module tb_fp16_mul_arbiter;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int TMO = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [16*N-1:0]   req_a;
  logic [16*N-1:0]   req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [15:0]       rsp_data;
  logic              rsp_err;
  logic [15:0]       mul_a;
  logic [15:0]       mul_b;
  logic              mul_start;
  logic              mul_clear;
  logic              mul_valid;
  logic [15:0]       mul_result;
  logic              busy;

  fp16_mul_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_start  (mul_start),
    .mul_clear  (mul_clear),
    .mul_valid  (mul_valid),
    .mul_result (mul_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // FP16 product for zeros and normal operands whose product is exact.
  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    logic [21:0] p;
    int          e;
    s = a[15] ^ b[15];
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'd0};
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) return {s, 5'(e + 1), p[20:11]};
    return {s, 5'(e), p[19:10]};
  endfunction

  // Which requester a round-robin search from ptr selects.
  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // Behavioural multiplier, updated away from the active edge.
  int          lat = 2;
  bit          stall = 1'b0;
  int          m_cnt = 0;
  bit          m_pend = 1'b0;
  logic [15:0] m_res = '0;
  int          start_cnt = 0;
  int          clear_cnt = 0;

  initial begin
    mul_valid  = 1'b0;
    mul_result = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mul_valid = 1'b0;
        m_pend    = 1'b0;
      end else begin
        if (mul_start) begin
          start_cnt++;
          m_pend = !stall;
          m_cnt  = lat;
          m_res  = fp16_mul(mul_a, mul_b);
        end else if (m_pend) begin
          m_cnt--;
          if (m_cnt == 0) begin
            mul_valid  = 1'b1;
            mul_result = m_res;
            m_pend     = 1'b0;
          end
        end
        if (mul_clear) begin
          clear_cnt++;
          mul_valid = 1'b0;
        end
      end
    end
  end

  int ptr_m = 0;

  logic [15:0] tab [11] = '{16'h3C00, 16'h4000, 16'h3800, 16'h4200, 16'h3E00,
                            16'hBC00, 16'hC000, 16'h0000, 16'h8000, 16'h4500, 16'h3400};

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = tab[$urandom_range(0, 10)];
      req_b[16*i +: 16] = tab[$urandom_range(0, 10)];
    end
  endtask

  // One complete operation: grant, start, result, clear, response handshake.
  task automatic run_op(input logic [N-1:0] vmask, input bit hold, input int bp,
                        input int l_cyc, input bit tmo);
    int          g;
    int          n;
    int          sc0;
    int          cc0;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [15:0] ed;
    lat   = l_cyc;
    stall = tmo;
    g     = rr_pick(ptr_m, vmask);
    ea    = req_a[16*g +: 16];
    eb    = req_b[16*g +: 16];
    ed    = tmo ? 16'h7E00 : fp16_mul(ea, eb);
    req_valid = vmask;
    rsp_ready = (bp == 0);
    #1;
    n = 0;
    while (req_ready == '0 && n < 50) begin
      step();
      n++;
    end
    check("grant", 64'(req_ready), 64'(N'(1) << g));
    sc0 = start_cnt;
    cc0 = clear_cnt;
    step();
    if (!hold) req_valid = '0;
    check("start", {mul_start, busy, req_ready, mul_a, mul_b}, {1'b1, 1'b1, N'(0), ea, eb});
    n = 1;
    while (!rsp_valid && n < 300) begin
      step();
      n++;
    end
    if (!rsp_valid) begin
      check("rsp_wait", 64'(rsp_valid), 64'(1));
      return;
    end
    check("latency", 64'(n), 64'(tmo ? TMO + 3 : l_cyc + 3));
    check("rsp", {rsp_id, rsp_data, rsp_err}, {IW'(g), ed, tmo});
    check("pulses", 64'((start_cnt - sc0) * 16 + (clear_cnt - cc0)), 64'(16 + 1));
    if (bp > 0) begin
      for (int i = 0; i < bp; i++) begin
        step();
        check("bp_hold", {rsp_valid, rsp_id, rsp_data, rsp_err, req_ready, mul_start},
              {1'b1, IW'(g), ed, tmo, N'(0), 1'b0});
      end
      check("bp_starts", 64'(start_cnt - sc0), 64'(1));
      rsp_ready = 1'b1;
    end
    step();
    check("rsp_done", 64'(rsp_valid), 64'(0));
    ptr_m = (g + 1) % N;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    step();
    step();
    check("reset_outs", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, mul_a, mul_b,
                         mul_start, mul_clear, busy}, 64'(0));
    reset = 1'b0;
    step();

    // Single request: requester 2, 1.0 * 2.0.
    req_a[32 +: 16] = 16'h3C00;
    req_b[32 +: 16] = 16'h4000;
    run_op(4'b0100, 1'b0, 0, 2, 1'b0);
    check("single_data", 64'(rsp_data), 64'(16'h4000));

    // Reset while WAITing: the operation vanishes and the pointer returns to 0.
    rand_ops();
    lat       = 20;
    stall     = 1'b0;
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    check("mid_grant", 64'(req_ready), 64'(4'b0010));
    step();
    req_valid = '0;
    step();
    step();
    check("mid_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_reset_outs", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, mul_a, mul_b,
                             mul_start, mul_clear, busy}, 64'(0));
    ptr_m = 0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
        step();
        if (rsp_valid || mul_start) seen++;
      end
      check("no_dropped_rsp", 64'(seen), 64'(0));
    end

    // Round robin with every requester asserting continuously: 0,1,2,3,0,1.
    rand_ops();
    for (int i = 0; i < 6; i++) begin
      run_op(4'b1111, 1'b1, 0, 1 + (i % 3), 1'b0);
      check("rr_order", 64'(rsp_id), 64'(i % N));
    end
    req_valid = '0;

    // Backpressure: rsp_ready low for 10 cycles.
    rand_ops();
    run_op(4'b1000, 1'b0, 10, 3, 1'b0);

    // Sign and zero: -1.0 * 0.0 gives -0.0.
    req_a[0 +: 16] = 16'hBC00;
    req_b[0 +: 16] = 16'h0000;
    run_op(4'b0001, 1'b0, 0, 2, 1'b0);
    check("signzero", 64'(rsp_data), 64'(16'h8000));

`ifdef FM_ARB_TIMEOUT_EN
    // Multiplier never answers: qNaN with rsp_err after TMO WAIT cycles.
    rand_ops();
    run_op(4'b0010, 1'b0, 2, 1, 1'b1);
`endif

    // Randomized traffic.
    for (int t = 0; t < 20; t++) begin
      rand_ops();
      run_op(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
             int'($urandom_range(1, 5)), 1'b0);
    end
    req_valid = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp16_mul_arbiter.md
# fp16_mul_arbiter

Shares one `fp16_multiplier` instance between `NUM_REQ` requesters using round-robin arbitration. It drives the multiplier's start/valid/clear handshake for each operation and returns the FP16 product to the winning requester, tagged with its index, over a valid/ready response channel. It sits between the NPU processing lanes and the single multiplier datapath.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16)
- `TIMEOUT_CYCLES`, 64, watchdog limit in WAIT; used only with `FM_ARB_TIMEOUT_EN`
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester operation request
- `req_ready`  out  NUM_REQ  one-hot accept; at most one bit high
- `req_a`  in  16*NUM_REQ  FP16 operand A, requester i at [16i+15:16i]
- `req_b`  in  16*NUM_REQ  FP16 operand B, same packing
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  result consumed
- `rsp_id`  out  $clog2(NUM_REQ)  index of the requester that owns the result
- `rsp_data`  out  16  FP16 product
- `rsp_err`  out  1  timeout flag (constant 0 without the macro)
- `mul_a`, `mul_b`  out  16  registered operands to the multiplier `input_a`/`input_b`
- `mul_start`  out  1  one-cycle start pulse
- `mul_clear`  out  1  one-cycle clear pulse
- `mul_valid`  in  1  multiplier `valid`
- `mul_result`  in  16  multiplier `result`
- `busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, START, WAIT, CLEAR, RESP.
- IDLE:
  - If any `req_valid` is high, the arbiter picks grant g by round-robin, searching from `ptr` upward modulo NUM_REQ.
  - It asserts `req_ready[g]` combinationally in the same cycle.
  - On the clock edge it registers `req_a[g]`/`req_b[g]` into `mul_a`/`mul_b` and g into `rsp_id`, then moves to START.
- START: `mul_start`=1 for exactly one cycle, then move to WAIT.
- WAIT:
  - When `mul_valid` is sampled high, register `mul_result` into `rsp_data`, then move to CLEAR.
- CLEAR: `mul_clear`=1 for exactly one cycle, then move to RESP.
- RESP:
  - `rsp_valid`=1, and it is held with `rsp_data`/`rsp_id`/`rsp_err` stable until `rsp_ready`.
  - On the handshake, set `ptr` to (g+1) mod NUM_REQ and return to IDLE.
- `req_ready` is 0 in every state except IDLE. Requests are never accepted while an operation is in flight.
- A requester that drops `req_valid` before it is granted loses nothing; no state is kept for it.
- `mul_a`/`mul_b` hold their values until the next grant.
- Reset: on the next edge the FSM goes to IDLE and `ptr` goes to 0. All outputs are 0: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_err`, `mul_a`, `mul_b`, `mul_start`, `mul_clear`, `busy`.
  - Any operation in flight is discarded and no response is issued.
  - The top level holds the multiplier in reset (`reset_b` = ~`reset`) during the same cycles.

## Timing
- Grant-to-start latency is 1 cycle. `mul_start` is high in the cycle after `req_ready[g]`.
- With L = number of cycles from `mul_start` to `mul_valid`:
  - `rsp_valid` first rises L+3 cycles after the accept edge.
  - Minimum issue period is L+5 cycles when `rsp_ready` is held high.
- `rsp_valid` rising while `rsp_ready` is already high completes the handshake in that same cycle. In that case `rsp_valid` is high for exactly 1 cycle.
- `mul_valid` is ignored outside WAIT, including a stale high in START.
- Round-robin wrap: after a grant to NUM_REQ-1, the search starts at 0.

## Configuration
- `FM_ARB_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT_CYCLES) runs in WAIT. It is cleared on entry to WAIT.
  - When it reaches TIMEOUT_CYCLES-1 with `mul_valid` still low:
    - `rsp_data` is set to 16'h7E00 (qNaN) and `rsp_err` is set to 1.
    - The FSM moves to CLEAR, then to RESP.
  - `rsp_err` clears on the RESP handshake.
- `FM_ARB_TIMEOUT_EN` undefined: WAIT has no time limit, `rsp_err` is tied to 0, and the counter is not built.

## Structure
- Shared package `fp16_mul_arb_pkg`, containing:
  - the state enum (IDLE, START, WAIT, CLEAR, RESP);
  - `FP16_QNAN` = 16'h7E00;
  - `FP16_W` = 16.
- Sub-module `fm_rr_arbiter` (pure combinational): inputs are `req_valid` and `ptr`; outputs are one-hot `grant` and the encoded `grant_id`.
- The FSM, operand/result registers and the timeout counter stay in the top module.

## Test plan
- Single request:
  - Stimulus: requester 2 presents a=16'h3C00 (1.0), b=16'h4000 (2.0); `rsp_ready`=1.
  - Required response: one `mul_start` pulse, then one `mul_clear` pulse after `mul_valid`; `rsp_id`=2, `rsp_data`=16'h4000.
- Round robin:
  - Stimulus: all 4 requesters hold `req_valid` high continuously.
  - Required response: grant order is 0,1,2,3,0,1; no requester is granted twice in a row.
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 10 cycles after `rsp_valid` rises.
  - Required response: `rsp_valid`/`rsp_data`/`rsp_id` stay stable, `req_ready` stays 0, and no new `mul_start` is issued.
- Reset mid-operation:
  - Stimulus: assert `reset` for 1 cycle while in WAIT.
  - Required response: next cycle all outputs are 0 and the FSM is in IDLE; no `rsp_valid` for the dropped operation; the next grant goes to requester 0.
- Timeout (macro on, TIMEOUT_CYCLES=8):
  - Stimulus: `mul_valid` held at 0.
  - Required response: after 8 WAIT cycles, one `mul_clear` pulse, then `rsp_valid`=1, `rsp_err`=1, `rsp_data`=16'h7E00.
- Sign/zero:
  - Stimulus: a=16'hBC00 (-1.0), b=16'h0000, and a behavioral multiplier model.
  - Required response: `rsp_data` equals the model's result, and the multiplier is cleared before the next grant.
